l2c_miss_sched: RTL and testbench

- Schedules L2C miss requests from N_REQ requesters onto the single MNI miss port, e.g. DL1, IL1, prefetcher and writeback buffer.
- Uses round-robin arbitration.
- Latches the winner's address, flags and write-enable, drives the MNI valid/stall handshake, and returns a one-cycle ack to the granted requester.
- Sits between the L1 miss sources and the MNI, and also drives the L2 datapath select (grant id).

---
 rtl/l2c_pkg.sv | 24 ++
 rtl/l2c_rr_arb.sv | 34 +++
 rtl/l2c_miss_sched.sv | 172 +++++++++++++++++
 tb/tb_l2c_miss_sched.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2c_pkg.sv
// l2c_pkg: shared definitions for the L2C miss scheduler.
//   - one-hot FSM state encoding
//   - request flag bit positions
//   - address alignment offsets and an alignment helper
package l2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_ISSUE = 3'b010,
    ST_DONE  = 3'b100
  } l2c_state_e;

  localparam int FLG_LINE = 1;
  localparam int FLG_UNC  = 0;
  localparam int LINE_OFS = 6;
  localparam int WORD_OFS = 2;

  // Line transfers are cache-line aligned, everything else word aligned.
  function automatic logic [31:0] align_adr(input logic [31:0] adr, input logic line);
    if (line) align_adr = (adr >> LINE_OFS) << LINE_OFS;
    else      align_adr = (adr >> WORD_OFS) << WORD_OFS;
  endfunction

endpackage

// File: rtl/l2c_rr_arb.sv
// l2c_rr_arb: combinational round-robin pick.
// The search starts one past the last winner and wraps, so the last winner
// has the lowest priority on the next pick.
// Ports:
//   req  - request vector
//   last - index of the previous winner
//   gnt  - one-hot grant (zero when nothing requests)
//   idx  - encoded grant index
//   any  - at least one request present
module l2c_rr_arb #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!any && req[(int'(last) + i) % N_REQ]) begin
        any = 1'b1;
        gnt[(int'(last) + i) % N_REQ] = 1'b1;
        idx = ID_W'((int'(last) + i) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/l2c_miss_sched.sv
// l2c_miss_sched: schedules L1-side miss requests onto the single MNI miss
// port with round-robin arbitration. The winner's address, flags and write
// enable are latched when it is picked and held for the whole transfer; a
// one-cycle ack returns to the winner once the MNI accepts.
//
// Optional build macro L2C_MISS_SCHED_WDOG_EN: adds a stall watchdog that
// aborts a transfer after WDOG_MAX stalled cycles, acking it with o_req_err
// and setting the sticky o_wdog_err. Without it o_req_err/o_wdog_err are 0
// and a stalled transfer waits indefinitely.
//
// Ports:
//   Clk, Reset        clock, synchronous active-high reset
//   i_ctl_en          cacheable-control enable (gates line transfers)
//   i_req/_wen/_adr/_flags  per-requester request and fields (packed)
//   o_req_ack         one-hot, one-cycle ack to the granted requester
//   o_req_err         qualifies o_req_ack: transfer was aborted
//   i_mni_miss_stall  MNI not accepting
//   o_mni_miss_valid/_adr/_flags/_wen  MNI request
//   o_grant_id        index of current or last winner (L2 datapath select)
//   o_wdog_err        sticky watchdog flag
module l2c_miss_sched
  import l2c_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int ID_W     = 2,
  parameter int WDOG_MAX = 1023
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  i_ctl_en,
  input  logic [N_REQ-1:0]      i_req,
  input  logic [N_REQ-1:0]      i_req_wen,
  input  logic [32*N_REQ-1:0]   i_req_adr,
  input  logic [2*N_REQ-1:0]    i_req_flags,
  output logic [N_REQ-1:0]      o_req_ack,
  output logic                  o_req_err,
  input  logic                  i_mni_miss_stall,
  output logic                  o_mni_miss_valid,
  output logic [31:0]           o_mni_miss_adr,
  output logic [1:0]            o_mni_miss_flags,
  output logic                  o_mni_miss_wen,
  output logic [ID_W-1:0]       o_grant_id,
  output logic                  o_wdog_err
);

  l2c_state_e        state_q, state_d;
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   grant_id_q;
  logic              wen_q;
  logic [N_REQ-1:0]  ack_q;
  logic [31:0]       adr_q;
  logic [1:0]        flags_q;

  logic [N_REQ-1:0]  arb_gnt;
  logic [ID_W-1:0]   arb_idx;
  logic              arb_any;

  logic [31:0]       sel_adr;
  logic [1:0]        sel_flags;
  logic              sel_wen;
  logic              line_mode;
  logic              grab;
  logic              finish;
  logic              timeout;

  l2c_rr_arb #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req  (i_req),
    .last (ptr_q),
    .gnt  (arb_gnt),
    .idx  (arb_idx),
    .any  (arb_any)
  );

  // Winner field select, driven by the one-hot grant.
  always_comb begin
    sel_adr   = '0;
    sel_flags = '0;
    sel_wen   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (arb_gnt[k]) begin
        sel_adr   = i_req_adr[32*k +: 32];
        sel_flags = i_req_flags[2*k +: 2];
        sel_wen   = i_req_wen[k];
      end
    end
  end

  assign line_mode = i_ctl_en & sel_flags[FLG_LINE] & ~sel_flags[FLG_UNC];
  assign grab      = (state_q == ST_IDLE) && arb_any;
  assign finish    = (state_q == ST_ISSUE) && (!i_mni_miss_stall || timeout);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (arb_any) state_d = ST_ISSUE;
      ST_ISSUE: if (finish)  state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Control registers: state, rr pointer, grant id, write enable, ack.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= ID_W'(N_REQ - 1);
      grant_id_q <= '0;
      wen_q      <= 1'b0;
      ack_q      <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= '0;
      if (grab) begin
        ptr_q      <= arb_idx;
        grant_id_q <= arb_idx;
        wen_q      <= sel_wen & ~line_mode;
      end
      if (finish) ack_q <= {{(N_REQ-1){1'b0}}, 1'b1} << grant_id_q;
    end
  end

  // Data registers: only meaningful while valid, so left out of reset.
  always_ff @(posedge Clk) begin
    if (grab) begin
      adr_q   <= align_adr(sel_adr, line_mode);
      flags_q <= {sel_flags[FLG_LINE] & i_ctl_en, sel_flags[FLG_UNC]};
    end
  end

`ifdef L2C_MISS_SCHED_WDOG_EN
  localparam int CNT_W = $clog2(WDOG_MAX + 1);

  logic [CNT_W-1:0] stall_cnt_q;
  logic             err_q;
  logic             wdog_q;

  // Counter holds the number of stalled ISSUE cycles already seen; the
  // WDOG_MAX-th stalled cycle is the one that aborts.
  assign timeout = (state_q == ST_ISSUE) && i_mni_miss_stall &&
                   (stall_cnt_q == CNT_W'(WDOG_MAX - 1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
      wdog_q      <= 1'b0;
    end else begin
      err_q <= timeout;
      if (timeout) wdog_q <= 1'b1;
      if (grab) stall_cnt_q <= '0;
      else if ((state_q == ST_ISSUE) && i_mni_miss_stall) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign o_req_err  = err_q;
  assign o_wdog_err = wdog_q;
`else
  logic unused_wdog;
  assign unused_wdog = (WDOG_MAX == 0);
  assign timeout     = 1'b0;
  assign o_req_err   = 1'b0;
  assign o_wdog_err  = 1'b0;
`endif

  assign o_req_ack        = ack_q;
  assign o_mni_miss_valid = (state_q == ST_ISSUE);
  assign o_mni_miss_adr   = adr_q;
  assign o_mni_miss_flags = flags_q;
  assign o_mni_miss_wen   = wen_q;
  assign o_grant_id       = grant_id_q;

endmodule

// File: tb/tb_l2c_miss_sched.sv
// Bench for l2c_miss_sched: directed scenarios with literal expectations,
// then randomized requesters/stall/reset, all checked every cycle against a
// transaction-level reference model.
module tb_l2c_miss_sched;

  localparam int NR = 4;
  localparam int IW = 2;
  localparam int WD = 8;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             i_ctl_en;
  logic [NR-1:0]    i_req;
  logic [NR-1:0]    i_req_wen;
  logic [32*NR-1:0] i_req_adr;
  logic [2*NR-1:0]  i_req_flags;
  logic [NR-1:0]    o_req_ack;
  logic             o_req_err;
  logic             i_mni_miss_stall;
  logic             o_mni_miss_valid;
  logic [31:0]      o_mni_miss_adr;
  logic [1:0]       o_mni_miss_flags;
  logic             o_mni_miss_wen;
  logic [IW-1:0]    o_grant_id;
  logic             o_wdog_err;

  int vectors = 0;
  int miscompares = 0;

  l2c_miss_sched #(.N_REQ(NR), .ID_W(IW), .WDOG_MAX(WD)) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .i_ctl_en         (i_ctl_en),
    .i_req            (i_req),
    .i_req_wen        (i_req_wen),
    .i_req_adr        (i_req_adr),
    .i_req_flags      (i_req_flags),
    .o_req_ack        (o_req_ack),
    .o_req_err        (o_req_err),
    .i_mni_miss_stall (i_mni_miss_stall),
    .o_mni_miss_valid (o_mni_miss_valid),
    .o_mni_miss_adr   (o_mni_miss_adr),
    .o_mni_miss_flags (o_mni_miss_flags),
    .o_mni_miss_wen   (o_mni_miss_wen),
    .o_grant_id       (o_grant_id),
    .o_wdog_err       (o_wdog_err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Transaction view: a transfer is either absent, in flight, or being
  // acknowledged. Winner = first requester after the last winner.
  bit          m_known = 1'b0;
  int          m_phase;          // 0 none, 1 in flight, 2 acknowledging
  int          m_last, m_gid, m_stalls;
  logic [31:0] m_adr;
  logic [1:0]  m_flags;
  logic        m_wen, m_err, m_wdog;
  logic [NR-1:0] m_ack;

  always @(posedge Clk) begin
    if (Reset) begin
      m_known = 1'b1;
      m_phase = 0; m_last = NR - 1; m_gid = 0; m_stalls = 0;
      m_wen = 1'b0; m_err = 1'b0; m_wdog = 1'b0; m_ack = '0;
    end else if (m_known) begin
      m_ack = '0;
      m_err = 1'b0;
      if (m_phase == 2) begin
        m_phase = 0;
      end else if (m_phase == 1) begin
        if (!i_mni_miss_stall) begin
          m_phase = 2;
          m_ack[m_gid] = 1'b1;
        end else begin
`ifdef L2C_MISS_SCHED_WDOG_EN
          m_stalls++;
          if (m_stalls == WD) begin
            m_phase = 2;
            m_ack[m_gid] = 1'b1;
            m_err = 1'b1;
            m_wdog = 1'b1;
          end
`endif
        end
      end else if (i_req != '0) begin
        bit found;
        found = 1'b0;
        for (int s = 1; s <= NR; s++) begin
          int c;
          c = (m_last + s) % NR;
          if (!found && i_req[c]) begin
            logic [31:0] a;
            logic [1:0]  f;
            logic        line;
            found = 1'b1;
            a = i_req_adr[32*c +: 32];
            f = i_req_flags[2*c +: 2];
            line = i_ctl_en && f[1] && !f[0];
            m_adr   = line ? (a & 32'hFFFF_FFC0) : (a & 32'hFFFF_FFFC);
            m_flags = {f[1] & i_ctl_en, f[0]};
            m_wen   = i_req_wen[c] & ~line;
            m_last  = c;
            m_gid   = c;
          end
        end
        m_phase  = 1;
        m_stalls = 0;
      end
    end
  end

  always @(negedge Clk) begin
    if (m_known) begin
      chk("m_valid", o_mni_miss_valid, (m_phase == 1));
      chk("m_ack", o_req_ack, m_ack);
      chk("m_gid", o_grant_id, m_gid);
      chk("m_wen", o_mni_miss_wen, m_wen);
      chk("m_err", o_req_err, m_err);
      chk("m_wdog", o_wdog_err, m_wdog);
      if (m_phase == 1) begin
        chk("m_adr", o_mni_miss_adr, m_adr);
        chk("m_flags", o_mni_miss_flags, m_flags);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_fields(input int k, input logic [31:0] a, input logic [1:0] f, input logic w);
    i_req_adr[32*k +: 32] = a;
    i_req_flags[2*k +: 2] = f;
    i_req_wen[k]          = w;
  endtask

  // Entered at +1 of an idle cycle; leaves at +1 of an idle cycle.
  task automatic single_req(input int k, input logic [31:0] a, input logic [1:0] f, input logic w,
                            input logic ctl, input logic [31:0] ea, input logic [1:0] ef, input logic ew);
    logic [NR-1:0] oh;
    oh = '0;
    oh[k] = 1'b1;
    set_fields(k, a, f, w);
    i_ctl_en = ctl;
    i_mni_miss_stall = 1'b0;
    i_req = oh;
    step();
    @(negedge Clk);
    chk("sr_valid", o_mni_miss_valid, 1);
    chk("sr_adr", o_mni_miss_adr, ea);
    chk("sr_flags", o_mni_miss_flags, ef);
    chk("sr_wen", o_mni_miss_wen, ew);
    chk("sr_gid", o_grant_id, k);
    step();
    @(negedge Clk);
    chk("sr_valid_done", o_mni_miss_valid, 0);
    chk("sr_ack", o_req_ack, oh);
    step();
    i_req = '0;
    step();
  endtask

  initial begin
    logic [NR-1:0] prev_ack;
    int nv, na;
    bit got;

    Reset = 1'b1;
    i_ctl_en = 1'b0;
    i_req = '0;
    i_req_wen = '0;
    i_req_adr = '0;
    i_req_flags = '0;
    i_mni_miss_stall = 1'b0;

    // Reset state
    step();
    @(negedge Clk);
    chk("rst_valid", o_mni_miss_valid, 0);
    chk("rst_ack", o_req_ack, 0);
    chk("rst_gid", o_grant_id, 0);
    chk("rst_wen", o_mni_miss_wen, 0);
    chk("rst_err", o_req_err, 0);
    chk("rst_wdog", o_wdog_err, 0);
    step();
    Reset = 1'b0;

    // Single line request
    single_req(0, 32'h1234_5677, 2'b10, 1'b0, 1'b1, 32'h1234_5640, 2'b10, 1'b0);
    chk("model_adr_pin", m_adr, 32'h1234_5640);
    chk("model_gid_pin", m_gid, 0);

    // All four requesting continuously
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    prev_ack = '0;
    nv = 0;
    na = 0;
    for (int c = 0; c < 15; c++) begin
      i_req = 4'hF & ~prev_ack;
      @(negedge Clk);
      if (o_mni_miss_valid) begin
        chk("rr_order", o_grant_id, nv % NR);
        nv++;
      end
      if (o_req_ack != '0) na++;
      prev_ack = o_req_ack;
      step();
    end
    chk("rr_grants", nv, 5);
    chk("rr_acks", na, 5);
    i_req = '0;
    step();
    step();

    // Stall for 5 cycles, address held despite input changes
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    set_fields(2, 32'h0000_1005, 2'b00, 1'b1);
    i_ctl_en = 1'b1;
    i_mni_miss_stall = 1'b1;
    i_req = 4'b0100;
    for (int c = 0; c < 6; c++) begin
      step();
      i_mni_miss_stall = (c < 5);
      i_req_adr[64 +: 32] = $urandom;
      @(negedge Clk);
      chk("st_valid", o_mni_miss_valid, 1);
      chk("st_adr", o_mni_miss_adr, 32'h0000_1004);
    end
    chk("st_wen", o_mni_miss_wen, 1);
    chk("st_gid", o_grant_id, 2);
    step();
    @(negedge Clk);
    chk("st_valid_done", o_mni_miss_valid, 0);
    chk("st_ack", o_req_ack, 4'b0100);
    step();
    i_req = '0;
    i_mni_miss_stall = 1'b0;
    step();

    // Word mode, then uncached line flags
    single_req(1, 32'hABCD_EF13, 2'b10, 1'b1, 1'b0, 32'hABCD_EF10, 2'b00, 1'b1);
    single_req(1, 32'hABCD_EF13, 2'b11, 1'b1, 1'b1, 32'hABCD_EF10, 2'b11, 1'b1);
    chk("model_flags_pin", m_flags, 2'b11);

    // Reset while a transfer is in flight
    set_fields(0, 32'h0000_0100, 2'b00, 1'b0);
    i_mni_miss_stall = 1'b1;
    i_req = 4'b0001;
    step();
    Reset = 1'b1;
    i_req = '0;
    @(negedge Clk);
    chk("ri_valid", o_mni_miss_valid, 1);
    step();
    Reset = 1'b0;
    i_mni_miss_stall = 1'b0;
    @(negedge Clk);
    chk("ri_valid_after", o_mni_miss_valid, 0);
    chk("ri_ack_after", o_req_ack, 0);
    step();
    single_req(2, 32'h0000_0047, 2'b01, 1'b1, 1'b1, 32'h0000_0044, 2'b01, 1'b1);

    // Stuck stall
    set_fields(0, 32'h0000_2000, 2'b00, 1'b0);
    i_mni_miss_stall = 1'b1;
    i_req = 4'b0001;
    nv = 0;
    got = 1'b0;
`ifdef L2C_MISS_SCHED_WDOG_EN
    for (int c = 0; c < 20 && !got; c++) begin
      step();
      @(negedge Clk);
      if (o_mni_miss_valid) nv++;
      if (o_req_ack != '0) begin
        got = 1'b1;
        chk("wd_ack", o_req_ack, 4'b0001);
        chk("wd_err", o_req_err, 1);
        chk("wd_flag", o_wdog_err, 1);
      end
    end
    chk("wd_got_ack", got, 1);
    chk("wd_issue_cycles", nv, WD);
    step();
    i_req = '0;
    i_mni_miss_stall = 1'b0;
    @(negedge Clk);
    chk("wd_idle_valid", o_mni_miss_valid, 0);
    chk("wd_sticky", o_wdog_err, 1);
    step();
`else
    for (int c = 0; c < 20; c++) begin
      step();
      @(negedge Clk);
      if (o_mni_miss_valid) nv++;
      if (o_req_ack != '0) got = 1'b1;
    end
    chk("hold_cycles", nv, 20);
    chk("hold_no_ack", got, 0);
    step();
    i_mni_miss_stall = 1'b0;
    step();
    @(negedge Clk);
    chk("hold_ack", o_req_ack, 4'b0001);
    chk("hold_err", o_req_err, 0);
    step();
    i_req = '0;
    step();
`endif

    // Randomized traffic
    prev_ack = '0;
    for (int c = 0; c < 3000; c++) begin
      Reset = ($urandom_range(0, 299) == 0);
      i_mni_miss_stall = ($urandom_range(0, 9) < 6);
      i_ctl_en = $urandom_range(0, 1);
      for (int k = 0; k < NR; k++) begin
        if (prev_ack[k]) begin
          i_req[k] = 1'b0;
        end else if (!i_req[k]) begin
          set_fields(k, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) i_req[k] = 1'b1;
        end
      end
      prev_ack = o_req_ack;
      step();
    end
    Reset = 1'b0;
    i_req = '0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
